axi_master: RTL
===============

AXI_MASTER -- requirements
Module: axi_master

Interface
REQ-001 ADDR_BITS, 32, address width.
REQ-002 DATA_BITS, 32, data width (8, 16, 32 or 64).
REQ-003 LEN_BITS, 8, burst length width (beats minus one).
REQ-004 SIZE_BITS, 3, burst size width.
REQ-005 aclk  in  1  clock; all logic on rising edge.
REQ-006 areset_n  in  1  reset; asynchronous, active-low.
REQ-007 cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-008 cmd_write in 1 (1=write, 0=read); cmd_addr in ADDR_BITS; cmd_len in LEN_BITS (beats-1).
REQ-009 wd_data in DATA_BITS; wd_valid in 1; wd_ready out 1: user write-payload stream.
REQ-010 rd_data out DATA_BITS; rd_valid out 1; rd_last out 1; rd_ready in 1: user read-payload stream.
REQ-011 done out 1: one-cycle completion pulse; resp out 2: completion response.
REQ-012 AW channel: aw_valid out 1, aw_ready in 1; outputs aw_addr ADDR_BITS, aw_len LEN_BITS, aw_size SIZE_BITS, aw_burst 2, aw_cache 4.
REQ-013 W channel: w_valid out 1, w_ready in 1; outputs w_data DATA_BITS, w_strb DATA_BITS/8, w_last 1.
REQ-014 B channel: b_valid in 1, b_ready out 1, b_resp in 2.
REQ-015 AR channel: ar_valid out 1, ar_ready in 1; outputs ar_addr, ar_len, ar_size, ar_burst, ar_cache, same widths as AW.
REQ-016 R channel: r_valid in 1, r_ready out 1, r_data in DATA_BITS, r_last in 1, r_resp in 2.

Function
REQ-017 Exactly one transaction outstanding; state register holds IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
REQ-018 cmd_ready = 1 only in IDLE. On cmd_valid&&cmd_ready: latch addr, len and write; next state is WR_ADDR if write, else RD_ADDR.
REQ-019 WR_ADDR/RD_ADDR: aw_valid/ar_valid registered high on entry. Address and length come from latched values and stay stable until aw_ready/ar_ready is sampled high. Valid never depends on ready. Handshake moves to WR_DATA/RD_DATA and drops valid the next cycle.
REQ-020 Fixed fields: aw_size/ar_size = log2(DATA_BITS/8); aw_burst/ar_burst = 2'b01 (INCR); aw_cache/ar_cache = 4'b0000; w_strb all ones.
REQ-021 WR_DATA: w_valid = wd_valid, w_data = wd_data, wd_ready = w_ready (combinational). Outside WR_DATA: w_valid = 0, wd_ready = 0.
REQ-022 A LEN_BITS beat counter clears on command accept and increments on each w_valid&&w_ready. w_last = (counter == latched len) while in WR_DATA.
REQ-023 Acceptance of the beat with w_last=1 moves to WR_RESP. cmd_len=0 means a single beat with w_last on the first beat. Len 255 means 256 beats and the counter never wraps.
REQ-024 WR_RESP: b_ready = 1. On b_valid: resp <= b_resp, done pulses the following cycle, state returns to IDLE.
REQ-025 RD_DATA: r_ready = rd_ready; rd_valid = r_valid, rd_data = r_data, rd_last = r_last (combinational). Outside RD_DATA: r_ready = 0, rd_valid = 0.
REQ-026 The beat counter increments on each r_valid&&r_ready. resp accumulates the first non-OKAY r_resp of the burst, else 2'b00.
REQ-027 Burst ends on r_valid&&r_ready&&r_last; then done pulses next cycle and state returns to IDLE.
REQ-028 If r_last does not coincide with counter == latched len (early or late), the burst still ends on r_last and resp = 2'b10.
REQ-029 done is high for exactly one cycle, in the first IDLE cycle. A new command may be accepted in that same cycle.
REQ-030 The master never increments addresses (incrementing is the responder's job). aw_addr/ar_addr hold the latched value.

Reset
REQ-031 While areset_n=0: state = IDLE, cmd_ready = 1; aw_valid, ar_valid, w_valid, b_ready, r_ready, wd_ready, rd_valid, done = 0; resp = 2'b00; latched addr/len and counter = 0.
REQ-032 Reset asserted mid-transaction aborts it immediately (asynchronous) with no done pulse. After release the block accepts a new command.

Verification
REQ-033 Write, addr=0x10, len=3, aw_ready delayed 2 cycles, w_ready always 1, b_resp=00 -> aw_valid held 3 cycles; 4 W beats with w_last only on the 4th; done=1 one cycle after B; resp=00.
REQ-034 Write, len=0, w_ready toggling -> single beat with w_last=1; wd_ready mirrors w_ready; no beat lost or duplicated.
REQ-035 Read, addr=0x20, len=2, rd_ready low for 2 cycles mid-burst -> r_ready follows rd_ready; 3 beats delivered in order; rd_last on the 3rd; done pulse; resp=00.
REQ-036 Read, len=3, responder asserts r_last on beat 2 -> burst ends on beat 2; resp=2'b10; return to IDLE. Second beat r_resp=01 with correct length -> resp=01.
REQ-037 areset_n low during WR_DATA beat 2 -> all valids/readies 0 within the same cycle; no done pulse; a following read, len=0, completes normally.
REQ-038 Back-to-back: cmd_valid held high with a second command -> second command accepted in the done cycle; no idle gap beyond that cycle.

Source files
------------

// File: rtl/axi_master.sv
// Single-outstanding AXI4 master: turns a command port plus write/read payload streams
// into one INCR burst at a time on the AW/W/B or AR/R channels.
module axi_master #(
   parameter int unsigned ADDR_BITS = 32,
   parameter int unsigned DATA_BITS = 32,
   parameter int unsigned LEN_BITS  = 8,
   parameter int unsigned SIZE_BITS = 3
) (
   input  logic                   aclk,
   input  logic                   areset_n,

   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [ADDR_BITS-1:0]   cmd_addr,
   input  logic [LEN_BITS-1:0]    cmd_len,

   input  logic [DATA_BITS-1:0]   wd_data,
   input  logic                   wd_valid,
   output logic                   wd_ready,

   output logic [DATA_BITS-1:0]   rd_data,
   output logic                   rd_valid,
   output logic                   rd_last,
   input  logic                   rd_ready,

   output logic                   done,
   output logic [1:0]             resp,

   output logic                   aw_valid,
   input  logic                   aw_ready,
   output logic [ADDR_BITS-1:0]   aw_addr,
   output logic [LEN_BITS-1:0]    aw_len,
   output logic [SIZE_BITS-1:0]   aw_size,
   output logic [1:0]             aw_burst,
   output logic [3:0]             aw_cache,

   output logic                   w_valid,
   input  logic                   w_ready,
   output logic [DATA_BITS-1:0]   w_data,
   output logic [DATA_BITS/8-1:0] w_strb,
   output logic                   w_last,

   input  logic                   b_valid,
   output logic                   b_ready,
   input  logic [1:0]             b_resp,

   output logic                   ar_valid,
   input  logic                   ar_ready,
   output logic [ADDR_BITS-1:0]   ar_addr,
   output logic [LEN_BITS-1:0]    ar_len,
   output logic [SIZE_BITS-1:0]   ar_size,
   output logic [1:0]             ar_burst,
   output logic [3:0]             ar_cache,

   input  logic                   r_valid,
   output logic                   r_ready,
   input  logic [DATA_BITS-1:0]   r_data,
   input  logic                   r_last,
   input  logic [1:0]             r_resp
);

   localparam int unsigned StrbBits = DATA_BITS / 8;
   localparam logic [SIZE_BITS-1:0] AxSize = SIZE_BITS'($clog2(StrbBits));
   localparam logic [1:0] BurstIncr = 2'b01;
   localparam logic [1:0] RespOkay  = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StWrAddr,
      StWrData,
      StWrResp,
      StRdAddr,
      StRdData
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_BITS-1:0]  addr_q, addr_d;
   logic [LEN_BITS-1:0]   len_q, len_d;
   logic [LEN_BITS-1:0]   cnt_q, cnt_d;
   logic [1:0]            resp_q, resp_d;
   logic                  done_q, done_d;
   // Set once a read beat past the expected last one has been accepted.
   logic                  ovr_q, ovr_d;
   logic                  beat_last;

   assign beat_last = (cnt_q == len_q);

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         resp_q  <= RespOkay;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      resp_d    = resp_q;
      ovr_d     = ovr_q;
      done_d    = 1'b0;
      cmd_ready = 1'b0;
      aw_valid  = 1'b0;
      ar_valid  = 1'b0;
      w_valid   = 1'b0;
      w_last    = 1'b0;
      wd_ready  = 1'b0;
      b_ready   = 1'b0;
      r_ready   = 1'b0;
      rd_valid  = 1'b0;
      rd_last   = 1'b0;

      case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               len_d   = cmd_len;
               cnt_d   = '0;
               resp_d  = RespOkay;
               ovr_d   = 1'b0;
               state_d = cmd_write ? StWrAddr : StRdAddr;
            end
         end

         StWrAddr: begin
            aw_valid = 1'b1;
            if (aw_ready) state_d = StWrData;
         end

         StWrData: begin
            w_valid  = wd_valid;
            wd_ready = w_ready;
            w_last   = beat_last;
            if (wd_valid && w_ready) begin
               // Hold the counter on the final beat so len=max never wraps.
               if (beat_last) state_d = StWrResp;
               else           cnt_d   = cnt_q + LEN_BITS'(1);
            end
         end

         StWrResp: begin
            b_ready = 1'b1;
            if (b_valid) begin
               resp_d  = b_resp;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end

         StRdAddr: begin
            ar_valid = 1'b1;
            if (ar_ready) state_d = StRdData;
         end

         StRdData: begin
            r_ready  = rd_ready;
            rd_valid = r_valid;
            rd_last  = r_last;
            if (r_valid && rd_ready) begin
               if (beat_last && !r_last) ovr_d = 1'b1;
               if (!beat_last)           cnt_d = cnt_q + LEN_BITS'(1);
               if (resp_q == RespOkay)   resp_d = r_resp;
               if (r_last) begin
                  // Responder's r_last disagrees with the requested length.
                  if (ovr_q || !beat_last) resp_d = RespSlvErr;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end

         default: state_d = StIdle;
      endcase
   end

   assign done     = done_q;
   assign resp     = resp_q;

   assign aw_addr  = addr_q;
   assign aw_len   = len_q;
   assign aw_size  = AxSize;
   assign aw_burst = BurstIncr;
   assign aw_cache = 4'b0000;

   assign ar_addr  = addr_q;
   assign ar_len   = len_q;
   assign ar_size  = AxSize;
   assign ar_burst = BurstIncr;
   assign ar_cache = 4'b0000;

   assign w_data   = wd_data;
   assign w_strb   = '1;
   assign rd_data  = r_data;

   // Protocol sanity: address channels hold until accepted; done is a single pulse.
   aw_hold_a : assert property (@(posedge aclk) disable iff (!areset_n)
      aw_valid && !aw_ready |=> aw_valid && $stable(aw_addr) && $stable(aw_len));

   ar_hold_a : assert property (@(posedge aclk) disable iff (!areset_n)
      ar_valid && !ar_ready |=> ar_valid && $stable(ar_addr) && $stable(ar_len));

   done_pulse_a : assert property (@(posedge aclk) disable iff (!areset_n)
      done |=> !done);

   done_idle_a : assert property (@(posedge aclk) disable iff (!areset_n)
      done |-> cmd_ready);

endmodule
